// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Turns spike trains back into numbers. Spikes on NUM_CH channels are counted
//   over a fixed WINDOW of enabled cycles. Each window yields the per-channel
//   counts, the index of the most active channel and a nonzero flag, offered
//   through a valid/ready handshake.
// Ports:
//   clk, reset (async, active-low)
//   enable      : 1 = sample spike_in every edge, 0 = idle and drop partial window
//   spike_in    : one spike flag per channel
//   counts_out  : latched counts, channel i in [i*CNT_W +: CNT_W]
//   winner      : channel with the largest latched count (ties -> lowest index)
//   any_spike   : at least one latched count is nonzero
//   out_valid   : a result is held on the outputs
//   out_ready   : consumer accepts the result
//   overrun     : sticky, an unaccepted result was overwritten

// One channel accumulator. final_cnt already includes this edge's spike, so
// the last-sample edge can latch it directly.
module spike_rate_lane #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             spike,
  output logic [CNT_W-1:0] final_cnt
);
  logic [CNT_W-1:0] acc;

  // Saturate at all-ones instead of wrapping.
  assign final_cnt = (spike && (acc != {CNT_W{1'b1}})) ? acc + 1'b1 : acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      acc <= '0;
    else if (clear)  acc <= '0;
    else             acc <= final_cnt;
  end
endmodule

module spike_rate_decoder #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 5,
  parameter int WINDOW = 16,
  parameter int IDX_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       spike_in,
  output logic [NUM_CH*CNT_W-1:0] counts_out,
  output logic [IDX_W-1:0]        winner,
  output logic                    any_spike,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);
  localparam int WCNT_W = $clog2(WINDOW);
  localparam logic [WCNT_W-1:0] LAST_POS = WCNT_W'(WINDOW - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic [NUM_CH-1:0][CNT_W-1:0] counts;
    logic [IDX_W-1:0]             winner;
    logic                         any;
  } result_t;

  state_t state, state_nxt;
  logic   sample, clear, last;
  logic [WCNT_W-1:0] wcnt;
  logic [NUM_CH-1:0][CNT_W-1:0] fin;
  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best_cnt;
  logic             fin_any;
  result_t          res_q;

  assign last = enable && (wcnt == LAST_POS);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Any disabled edge discards the partial window; an enabled edge samples,
  // and the last sample of a window also clears for back-to-back windows.
  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    clear     = 1'b1;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = ACCUM;
          sample    = 1'b1;
          clear     = last;
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          sample = 1'b1;
          clear  = last;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 wcnt <= '0;
    else if (!sample || last)   wcnt <= '0;
    else                        wcnt <= wcnt + 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_lane
      spike_rate_lane #(.CNT_W(CNT_W)) u_lane (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .spike     (spike_in[g] & sample),
        .final_cnt (fin[g])
      );
    end
  endgenerate

  // Linear max scan; strict '>' keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_cnt = fin[0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (fin[i] > best_cnt) begin
        best_cnt = fin[i];
        best_idx = IDX_W'(i);
      end
    end
    fin_any = (fin != '0);
  end

  // A latching edge wins over a transfer on the same edge: valid stays high
  // with fresh data. Overrun only when the held result was not taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (last) begin
      res_q     <= '{counts: fin, winner: best_idx, any: fin_any};
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign counts_out = res_q.counts;
  assign winner     = res_q.winner;
  assign any_spike  = res_q.any;
endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;
  localparam int NC = 4, CW = 5, W = 16, MAXC = 31;

  logic clk = 0, reset = 0;
  logic enable = 0, out_ready = 0;
  logic [NC-1:0] spike_in = '0;
  logic [NC*CW-1:0] counts_out;
  logic [1:0] winner;
  logic any_spike, out_valid, overrun;

  logic enable2 = 0;
  logic [NC-1:0] spike2 = '0;
  logic [NC*CW-1:0] counts2;
  logic [1:0] winner2;
  logic any2, valid2, ovr2;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.NUM_CH(NC), .CNT_W(CW), .WINDOW(W), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
    .counts_out(counts_out), .winner(winner), .any_spike(any_spike),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun));

  spike_rate_decoder #(.NUM_CH(NC), .CNT_W(CW), .WINDOW(40), .IDX_W(2)) dut40 (
    .clk(clk), .reset(reset), .enable(enable2), .spike_in(spike2),
    .counts_out(counts2), .winner(winner2), .any_spike(any2),
    .out_valid(valid2), .out_ready(1'b1), .overrun(ovr2));

  // Reference model: raw spike tallies per window, clamped only when reported.
  int  tally[NC];
  int  pos;
  bit  m_valid, m_ovr, m_any;
  int  m_cnt[NC];
  int  m_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (tally[i]) begin tally[i] = 0; m_cnt[i] = 0; end
    pos = 0; m_valid = 0; m_ovr = 0; m_any = 0; m_win = 0;
  endtask

  task automatic model_edge(input bit en, input logic [NC-1:0] sp, input bit rdy);
    bit xfer;
    xfer = m_valid && rdy;
    if (!en) begin
      foreach (tally[i]) tally[i] = 0;
      pos = 0;
      if (xfer) m_valid = 0;
      return;
    end
    foreach (tally[i]) tally[i] += sp[i];
    if (pos == W - 1) begin
      if (m_valid && !rdy) m_ovr = 1;
      m_win = 0; m_any = 0;
      foreach (tally[i]) begin
        m_cnt[i] = (tally[i] > MAXC) ? MAXC : tally[i];
        if (m_cnt[i] > m_cnt[m_win]) m_win = i;
        if (m_cnt[i] != 0) m_any = 1;
        tally[i] = 0;
      end
      m_valid = 1;
      pos = 0;
    end else begin
      pos++;
      if (xfer) m_valid = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NC*CW-1:0] exp_c;
    for (int i = 0; i < NC; i++) exp_c[i*CW +: CW] = CW'(m_cnt[i]);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    if (m_valid) begin
      chk({tag, ".counts"}, 32'(counts_out), 32'(exp_c));
      chk({tag, ".winner"}, 32'(winner), 32'(m_win));
      chk({tag, ".any"}, 32'(any_spike), 32'(m_any));
    end
  endtask

  // Inputs change at negedge, outputs checked at the following negedge.
  task automatic tick(input string tag, input bit en, input logic [NC-1:0] sp, input bit rdy);
    enable = en; spike_in = sp; out_ready = rdy;
    @(posedge clk);
    model_edge(en, sp, rdy);
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    logic [NC*CW-1:0] exp_pk;
    int first_valid;
    model_reset();

    // Reset held with spikes active and enable high.
    enable = 1; spike_in = '1; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst.counts", 32'(counts_out), 0);
    chk("rst.winner", 32'(winner), 0);
    chk("rst.any", 32'(any_spike), 0);
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.overrun", 32'(overrun), 0);
    reset = 1;

    // Window 1: ch0 every cycle.
    for (int k = 0; k < W; k++) tick("w1", 1, 4'b0001, 1);
    exp_pk = '0; exp_pk[0 +: CW] = 5'd16;
    chk("w1.counts_dir", 32'(counts_out), 32'(exp_pk));
    chk("w1.valid_dir", 32'(out_valid), 1);

    // Window 2: ch1/ch3 five spikes, ch2 three spikes; tie -> winner 1.
    for (int k = 0; k < W; k++)
      tick("w2", 1, {k < 5, k < 3, k < 5, 1'b0}, 1);
    chk("w2.counts_dir", 32'(counts_out), 32'({5'd5, 5'd3, 5'd5, 5'd0}));
    chk("w2.winner_dir", 32'(winner), 1);

    // Overrun: two windows with out_ready low (first edge still transfers w2).
    tick("ovA", 1, 4'b0010, 1);
    for (int k = 1; k < W; k++) tick("ovA", 1, 4'b0010, 0);
    for (int k = 0; k < W; k++) tick("ovB", 1, 4'b1000, 0);
    exp_pk = '0; exp_pk[3*CW +: CW] = 5'd16;
    chk("ov.counts_dir", 32'(counts_out), 32'(exp_pk));
    chk("ov.overrun_dir", 32'(overrun), 1);
    chk("ov.valid_dir", 32'(out_valid), 1);
    tick("ov.drain", 0, 4'b0000, 1);
    chk("ov.drained", 32'(out_valid), 0);
    chk("ov.sticky", 32'(overrun), 1);

    // Partial window of 8 samples discarded, then re-enable.
    for (int k = 0; k < 8; k++) tick("part", 1, 4'b0100, 1);
    for (int k = 0; k < 3; k++) tick("part.off", 0, 4'b1111, 1);
    first_valid = -1;
    for (int k = 0; k < W; k++) begin
      tick("reen", 1, 4'b0001, 1);
      if (out_valid && first_valid < 0) first_valid = k + 1;
    end
    chk("reen.latency", 32'(first_valid), 32'(W));
    chk("reen.ch2", 32'(counts_out[2*CW +: CW]), 0);

    // Randomized traffic.
    for (int k = 0; k < 300; k++)
      tick("rand", ($urandom_range(0, 9) != 0), NC'($urandom), 1'($urandom));

    // Build up state, then async reset mid-window.
    for (int k = 0; k < W + 5; k++) tick("pre_rst", 1, NC'($urandom), 0);
    enable = 0;
    #2 reset = 0;
    #1;
    chk("mid_rst.counts", 32'(counts_out), 0);
    chk("mid_rst.valid", 32'(out_valid), 0);
    chk("mid_rst.overrun", 32'(overrun), 0);
    chk("mid_rst.winner", 32'(winner), 0);
    #1 reset = 1;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < W + 3; k++) tick("post_rst", 1, NC'($urandom), 1);
    enable = 0;

    // WINDOW=40 instance: ch2 every cycle saturates at 31.
    enable2 = 1; spike2 = 4'b0100;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 38) chk("w40.valid_early", 32'(valid2), 0);
    end
    chk("w40.valid", 32'(valid2), 1);
    chk("w40.ch2", 32'(counts2[2*CW +: CW]), 31);
    chk("w40.winner", 32'(winner2), 2);
    chk("w40.any", 32'(any2), 1);
    enable2 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
